// File: rtl/sd_sdp_framer_if.sv
// Framer bus: frame requests, payload FIFO head/pop, and byte-coder handshake.
// slave = framer side, master = request source / FIFO / coder side.
interface sd_sdp_framer_if #(parameter int LW = 16);
    logic          sd_s_req;
    logic          sd_d_req;
    logic [LW-1:0] pl_len;
    logic          rx_err;
    logic          sd_busy;
    logic [7:0]    pl_d;
    logic          pl_vld;
    logic          pl_rd;
    logic          cd_busy;
    logic [7:0]    q;
    logic          q_rdy;
    logic          msg_end;
    logic          frm_busy;

    modport slave (
        input  sd_s_req, sd_d_req, pl_len, rx_err, sd_busy, pl_d, pl_vld, cd_busy,
        output pl_rd, q, q_rdy, msg_end, frm_busy
    );
    modport master (
        output sd_s_req, sd_d_req, pl_len, rx_err, sd_busy, pl_d, pl_vld, cd_busy,
        input  pl_rd, q, q_rdy, msg_end, frm_busy
    );
endinterface

// File: rtl/sd_sdp_framer.sv
// Slave-response framer: MARKER, STATUS, length field (MSB first), payload, optional CRC-8 trailer.
// Define SD_SDP_CRC_EN to append the CRC-8 (poly 0x07, init 0) trailer byte.
module sd_sdp_framer #(
    parameter logic [7:0] MARKER    = 8'hA5,
    parameter int         LEN_BYTES = 2,
    parameter int         MAX_PL    = 1024
) (
    input logic           clk,
    input logic           n_rst,
    sd_sdp_framer_if.slave bus
);
    localparam int LW = 8 * LEN_BYTES;
    localparam int CW = $clog2(MAX_PL + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_MARK, S_STAT, S_LEN, S_PL,
`ifdef SD_SDP_CRC_EN
        S_CRC,
`endif
        S_END
    } state_t;

    typedef enum logic [1:0] {PH_SEND, PH_WAIT_HI, PH_WAIT_LO} phase_t;

`ifdef SD_SDP_CRC_EN
    localparam state_t AFTER_PL = S_CRC;
`else
    localparam state_t AFTER_PL = S_END;
`endif

    state_t        state, state_nxt;
    phase_t        ph, ph_nxt;
    logic [1:0]    k;
    logic [CW-1:0] pl_cnt;
    logic [LW-1:0] len_q, len_in, len_sh;
    logic [7:0]    stat_q, cur_byte, q_r;
    logic          q_rdy_r, pl_rd_r, msg_end_r;
    logic          take, send, done, len_ovf, last_k, len_zero, pl_last;

    assign bus.q        = q_r;
    assign bus.q_rdy    = q_rdy_r;
    assign bus.pl_rd    = pl_rd_r;
    assign bus.msg_end  = msg_end_r;
    assign bus.frm_busy = (state != S_IDLE);

    assign len_ovf  = 64'(bus.pl_len) > 64'(MAX_PL);
    assign len_in   = !bus.sd_d_req ? '0 : (len_ovf ? LW'(MAX_PL) : bus.pl_len);
    assign len_sh   = len_q << {k, 3'b000};
    assign last_k   = (k == 2'(LEN_BYTES - 1));
    assign len_zero = (len_q == '0);
    // pl_cnt already counts the byte in flight, so equality marks the last one
    assign pl_last  = (64'(pl_cnt) == 64'(len_q));

`ifdef SD_SDP_CRC_EN
    logic [7:0] crc_q;

    function automatic logic [7:0] crc8_upd(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] x;
        x = c ^ d;
        for (int i = 0; i < 8; i++)
            x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
        return x;
    endfunction
`endif

    always_comb begin
        case (state)
            S_MARK:  cur_byte = MARKER;
            S_STAT:  cur_byte = stat_q;
            S_LEN:   cur_byte = len_sh[LW-1 -: 8];
            S_PL:    cur_byte = bus.pl_d;
`ifdef SD_SDP_CRC_EN
            S_CRC:   cur_byte = crc_q;
`endif
            default: cur_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_nxt = state;
        ph_nxt    = ph;
        take      = 1'b0;
        send      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.sd_s_req || bus.sd_d_req) begin
                    take      = 1'b1;
                    state_nxt = S_MARK;
                    ph_nxt    = PH_SEND;
                end
            end
            S_END: state_nxt = S_IDLE;
            default: begin
                case (ph)
                    PH_SEND: begin
                        // payload bytes stall here while the FIFO is empty
                        if (!bus.cd_busy && (state != S_PL || bus.pl_vld)) begin
                            send   = 1'b1;
                            ph_nxt = PH_WAIT_HI;
                        end
                    end
                    PH_WAIT_HI: if (bus.cd_busy) ph_nxt = PH_WAIT_LO;
                    PH_WAIT_LO: begin
                        if (!bus.cd_busy) begin
                            done   = 1'b1;
                            ph_nxt = PH_SEND;
                            case (state)
                                S_MARK:  state_nxt = S_STAT;
                                S_STAT:  state_nxt = S_LEN;
                                S_LEN:   if (last_k) state_nxt = len_zero ? AFTER_PL : S_PL;
                                S_PL:    if (pl_last) state_nxt = AFTER_PL;
`ifdef SD_SDP_CRC_EN
                                S_CRC:   state_nxt = S_END;
`endif
                                default: state_nxt = state;
                            endcase
                        end
                    end
                    default: ph_nxt = PH_SEND;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= S_IDLE;
            ph        <= PH_SEND;
            k         <= '0;
            pl_cnt    <= '0;
            len_q     <= '0;
            stat_q    <= '0;
            q_r       <= '0;
            q_rdy_r   <= 1'b0;
            pl_rd_r   <= 1'b0;
            msg_end_r <= 1'b0;
        end else begin
            state     <= state_nxt;
            ph        <= ph_nxt;
            q_rdy_r   <= send;
            pl_rd_r   <= send && (state == S_PL);
            msg_end_r <= (state != S_END) && (state_nxt == S_END);
            if (send) q_r <= cur_byte;
            if (take) begin
                stat_q <= {3'b000, bus.sd_d_req, bus.sd_d_req && len_ovf,
                           bus.sd_busy, bus.pl_vld, bus.rx_err};
                len_q  <= len_in;
                k      <= '0;
                pl_cnt <= '0;
            end
            if (send && state == S_PL) pl_cnt <= pl_cnt + CW'(1);
            if (done && state == S_LEN && !last_k) k <= k + 2'd1;
        end
    end

`ifdef SD_SDP_CRC_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            crc_q <= 8'h00;
        else if (take)
            crc_q <= 8'h00;
        else if (send && state != S_CRC)
            crc_q <= crc8_upd(crc_q, cur_byte);
    end
`endif
endmodule

// File: tb/tb_sd_sdp_framer.sv
// Bench for sd_sdp_framer: behavioural coder/FIFO, frame scoreboard, timing counters.
module tb_sd_sdp_framer;
    localparam int         LEN_BYTES = 2;
    localparam int         LW        = 8 * LEN_BYTES;
    localparam int         MAX_PL    = 1024;
    localparam logic [7:0] MARKER    = 8'hA5;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    sd_sdp_framer_if #(.LW(LW)) bus();

    sd_sdp_framer #(.MARKER(MARKER), .LEN_BYTES(LEN_BYTES), .MAX_PL(MAX_PL)) dut (
        .clk(clk), .n_rst(n_rst), .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    logic [7:0] fifo_q[$];

    int n_qrdy, n_plrd, plrd_mis, n_end, end_gap, end_cyc, first_qrdy;
    int busy_gap, stall_qrdy, extra_qrdy, last_fall, pops, stall_left;
    logic end_busy_after;
    bit timed_out;

    // bit-serial reference CRC-8, poly 0x07, MSB first
    function automatic logic [7:0] crc_ref(input logic [7:0] c, input logic [7:0] d);
        logic fb;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
    endfunction

    function automatic logic [7:0] status_of(input bit d, input int unsigned len, input bit sb,
                                             input bit vld, input bit rxe);
        return {3'b000, d, d && (len > MAX_PL), sb, vld, rxe};
    endfunction

    function automatic void push_frame(input bit is_d, input int unsigned len_in,
                                       input logic [7:0] status);
        logic [7:0]    fr[$];
        logic [LW-1:0] lv;
        int            n;
        if (!is_d) n = 0;
        else if (len_in > MAX_PL) n = MAX_PL;
        else n = int'(len_in);
        lv = LW'(n);
        fr.push_back(MARKER);
        fr.push_back(status);
        for (int k = 0; k < LEN_BYTES; k++) fr.push_back(lv[LW-1-8*k -: 8]);
        for (int i = 0; i < n; i++) fr.push_back(fifo_q[i]);
`ifdef SD_SDP_CRC_EN
        begin
            logic [7:0] crc;
            crc = 8'h00;
            foreach (fr[i]) crc = crc_ref(crc, fr[i]);
            fr.push_back(crc);
        end
`endif
        foreach (fr[i]) exp_q.push_back(fr[i]);
    endfunction

    task automatic drive_pins();
        bus.pl_vld = (fifo_q.size() > 0) && (stall_left == 0);
        bus.pl_d   = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    endtask

    task automatic req(input bit s, input bit d, input int unsigned len, input bit rxe, input bit sb);
        @(negedge clk);
        bus.sd_s_req = s;
        bus.sd_d_req = d;
        bus.pl_len   = LW'(len);
        bus.rx_err   = rxe;
        bus.sd_busy  = sb;
        stall_left   = 0;
        drive_pins();
    endtask

    // Acts as line coder and FIFO; records what the DUT emits. Cycle 1 = first cycle after request.
    task automatic serve(input int max_cyc, input int stall_at, input int stall_len,
                         input int inj_at, input int abort_pops, input int post);
        int cyc, busy_left, post_left;
        cyc = 0; busy_left = 0; post_left = -1;
        obs_q.delete();
        n_qrdy = 0; n_plrd = 0; plrd_mis = 0; n_end = 0; end_gap = -1; end_cyc = -10;
        first_qrdy = -1; busy_gap = 0; stall_qrdy = 0; extra_qrdy = 0; last_fall = -100;
        pops = 0; stall_left = 0; timed_out = 0; end_busy_after = 1'bx;
        while (1) begin
            @(negedge clk);
            cyc++;
            bus.sd_s_req = 1'b0;
            bus.sd_d_req = (cyc == inj_at);
            if (cyc == end_cyc + 1) end_busy_after = bus.frm_busy;
            if (bus.q_rdy) begin
                obs_q.push_back(bus.q);
                n_qrdy++;
                if (first_qrdy < 0) first_qrdy = cyc;
                if (post_left >= 0) extra_qrdy++;
                if (stall_left > 0) stall_qrdy++;
            end
            if (stall_left > 0) stall_left--;
            if (bus.pl_rd) begin
                n_plrd++;
                if (!bus.q_rdy) plrd_mis++;
                if (fifo_q.size() > 0) void'(fifo_q.pop_front());
                pops++;
                if (pops == stall_at) stall_left = stall_len;
            end
            if (n_end == 0 && !bus.frm_busy) busy_gap++;
            if (bus.msg_end) begin
                n_end++;
                if (end_gap < 0) begin
                    end_gap = cyc - last_fall;
                    end_cyc = cyc;
                    post_left = post;
                end
            end
            if (bus.q_rdy) begin
                bus.cd_busy = 1'b1;
                busy_left = 3;
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin
                    bus.cd_busy = 1'b0;
                    last_fall = cyc;
                end
            end
            drive_pins();
            if (abort_pops > 0 && pops >= abort_pops) break;
            if (post_left == 0) break;
            if (post_left > 0) post_left--;
            if (cyc >= max_cyc) begin
                timed_out = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.sd_s_req = 0; bus.sd_d_req = 0; bus.pl_len = '0; bus.rx_err = 0; bus.sd_busy = 0;
        bus.pl_d = 0; bus.pl_vld = 0; bus.cd_busy = 0;
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.q, bus.q_rdy, bus.pl_rd, bus.msg_end, bus.frm_busy} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs got q=%h q_rdy=%b pl_rd=%b msg_end=%b frm_busy=%b exp all 0",
                     bus.q, bus.q_rdy, bus.pl_rd, bus.msg_end, bus.frm_busy);
        end
        n_rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_status_only();
        fifo_q.delete();
        req(1, 0, 0, 1, 0);
        push_frame(0, 0, status_of(0, 0, 0, 0, 1));
        serve(500, -1, 0, -1, 0, 4);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++; $display("FAIL s_req frame_len got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [7:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL s_req byte got=%h exp=%h", o, e); end
        end
        exp_q.delete();
        checks++;
        if (first_qrdy !== 2) begin failures++; $display("FAIL s_req latency got=%0d exp=2", first_qrdy); end
        checks++;
        if (n_end !== 1 || end_gap !== 1) begin
            failures++; $display("FAIL s_req msg_end count=%0d gap=%0d exp 1/1", n_end, end_gap);
        end
        checks++;
        if (n_plrd !== 0) begin failures++; $display("FAIL s_req pl_rd got=%0d exp=0", n_plrd); end
        checks++;
        if (busy_gap !== 0 || end_busy_after !== 1'b0) begin
            failures++; $display("FAIL s_req frm_busy gaps=%0d after_end=%b exp 0/0", busy_gap, end_busy_after);
        end
    endtask

    task automatic test_payload();
        fifo_q.delete();
        req(0, 1, 3, 0, 0);
        fifo_q = '{8'h11, 8'h22, 8'h33};
        push_frame(1, 3, status_of(1, 3, 0, 0, 0));
        serve(500, -1, 0, -1, 0, 4);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++; $display("FAIL payload frame_len got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [7:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL payload byte got=%h exp=%h", o, e); end
        end
        exp_q.delete();
        checks++;
        if (n_plrd !== 3 || plrd_mis !== 0) begin
            failures++; $display("FAIL payload pl_rd got=%0d misaligned=%0d exp 3/0", n_plrd, plrd_mis);
        end
        checks++;
        if (n_end !== 1 || end_gap !== 1) begin
            failures++; $display("FAIL payload msg_end count=%0d gap=%0d exp 1/1", n_end, end_gap);
        end
    endtask

    task automatic test_clamp();
        fifo_q.delete();
        for (int i = 0; i < 1100; i++) fifo_q.push_back(8'((i * 7 + 3) & 8'hFF));
        req(0, 1, 2000, 0, 1);
        push_frame(1, 2000, status_of(1, 2000, 1, 1, 0));
        serve(9000, -1, 0, -1, 0, 4);
        checks++;
        if (obs_q.size() !== exp_q.size() || timed_out) begin
            failures++; $display("FAIL clamp frame_len got=%0d exp=%0d timeout=%0d", obs_q.size(), exp_q.size(), timed_out);
        end
        checks++;
        if (obs_q.size() > 3 && (obs_q[1][3] !== 1'b1 || {obs_q[2], obs_q[3]} !== 16'h0400)) begin
            failures++; $display("FAIL clamp header got status=%h len=%h%h exp bit3=1 len=0400", obs_q[1], obs_q[2], obs_q[3]);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [7:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL clamp byte got=%h exp=%h", o, e); end
        end
        exp_q.delete();
        checks++;
        if (n_plrd !== MAX_PL || n_end !== 1) begin
            failures++; $display("FAIL clamp pl_rd=%0d msg_end=%0d exp %0d/1", n_plrd, n_end, MAX_PL);
        end
    endtask

    task automatic test_underflow();
        fifo_q.delete();
        fifo_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6};
        req(0, 1, 6, 1, 0);
        push_frame(1, 6, status_of(1, 6, 0, 1, 1));
        serve(1000, 3, 20, -1, 0, 4);
        checks++;
        if (stall_qrdy !== 0) begin failures++; $display("FAIL underflow q_rdy_in_stall got=%0d exp=0", stall_qrdy); end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++; $display("FAIL underflow frame_len got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [7:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL underflow byte got=%h exp=%h", o, e); end
        end
        exp_q.delete();
        checks++;
        if (n_plrd !== 6 || n_end !== 1) begin
            failures++; $display("FAIL underflow pl_rd=%0d msg_end=%0d exp 6/1", n_plrd, n_end);
        end
    endtask

    task automatic test_collide();
        fifo_q.delete();
        fifo_q = '{8'hAA, 8'hBB};
        req(1, 1, 2, 0, 0);
        push_frame(1, 2, status_of(1, 2, 0, 1, 0));
        serve(1000, -1, 0, 10, 0, 12);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++; $display("FAIL collide frame_len got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [7:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL collide byte got=%h exp=%h", o, e); end
        end
        exp_q.delete();
        checks++;
        if (n_end !== 1 || extra_qrdy !== 0) begin
            failures++; $display("FAIL collide msg_end=%0d extra_q_rdy=%0d exp 1/0", n_end, extra_qrdy);
        end
    endtask

    task automatic test_reset_mid();
        int bad_end;
        fifo_q.delete();
        fifo_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        req(0, 1, 5, 0, 0);
        serve(1000, -1, 0, -1, 2, 0);
        n_rst = 1'b0;
        #1;
        checks++;
        if ({bus.q, bus.q_rdy, bus.pl_rd, bus.msg_end, bus.frm_busy} !== 12'h000) begin
            failures++;
            $display("FAIL reset_mid outputs got q=%h q_rdy=%b pl_rd=%b msg_end=%b frm_busy=%b exp all 0",
                     bus.q, bus.q_rdy, bus.pl_rd, bus.msg_end, bus.frm_busy);
        end
        bad_end = n_end;
        bus.cd_busy = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.msg_end) bad_end++;
        end
        checks++;
        if (bad_end !== 0) begin failures++; $display("FAIL reset_mid msg_end got=%0d exp=0", bad_end); end
        n_rst = 1'b1;
        fifo_q.delete();
        req(1, 0, 0, 0, 1);
        push_frame(0, 0, status_of(0, 0, 1, 0, 0));
        serve(500, -1, 0, -1, 0, 4);
        checks++;
        if (obs_q.size() !== exp_q.size() || n_end !== 1) begin
            failures++; $display("FAIL reset_mid clean_frame len=%0d exp=%0d msg_end=%0d", obs_q.size(), exp_q.size(), n_end);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [7:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL reset_mid byte got=%h exp=%h", o, e); end
        end
        exp_q.delete();
    endtask

`ifdef SD_SDP_CRC_EN
    task automatic test_crc();
        logic [7:0] crc;
        fifo_q.delete();
        fifo_q = '{8'h5A};
        req(0, 1, 1, 0, 0);
        crc = 8'h00;
        crc = crc_ref(crc, MARKER);
        crc = crc_ref(crc, status_of(1, 1, 0, 1, 0));
        crc = crc_ref(crc, 8'h00);
        crc = crc_ref(crc, 8'h01);
        crc = crc_ref(crc, 8'h5A);
        push_frame(1, 1, status_of(1, 1, 0, 1, 0));
        serve(500, -1, 0, -1, 0, 4);
        checks++;
        if (obs_q.size() !== 6 || obs_q[5] !== crc) begin
            failures++; $display("FAIL crc trailer len=%0d got=%h exp=%h", obs_q.size(),
                                 (obs_q.size() > 5) ? obs_q[5] : 8'hxx, crc);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [7:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL crc byte got=%h exp=%h", o, e); end
        end
        exp_q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_status_only();
        test_payload();
        test_clamp();
        test_underflow();
        test_collide();
        test_reset_mid();
`ifdef SD_SDP_CRC_EN
        test_crc();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
